// File: rtl/alu_operand_stage.sv
// Issue stage in front of the RV32 ALU: resolves operands, builds alu_ctrl,
// and steers them into the ALU operand order behind a skid-buffered handshake.
module alu_operand_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7b5,
  input  logic                  in_is_imm,
  input  logic [4:0]            in_rs1_addr,
  input  logic [4:0]            in_rs2_addr,
  input  logic [4:0]            in_rd_addr,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  mem_fwd_en,
  input  logic [4:0]            mem_fwd_rd,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data,
  input  logic                  wb_fwd_en,
  input  logic [4:0]            wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0] wb_fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] bus_A,
  output logic [DATA_WIDTH-1:0] bus_B,
  output logic [3:0]            alu_ctrl,
  output logic [4:0]            out_rd_addr,
  output logic [31:0]           issue_count
);

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [3:0] CTRL_SUB = 4'b0001;

  // MEM beats WB beats regfile; x0 is hardwired to zero.
  function automatic logic [DATA_WIDTH-1:0] resolve_src(
    input logic [4:0]            addr,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  m_en,
    input logic [4:0]            m_rd,
    input logic [DATA_WIDTH-1:0] m_data,
    input logic                  w_en,
    input logic [4:0]            w_rd,
    input logic [DATA_WIDTH-1:0] w_data
  );
    if (addr == 5'd0)                 return '0;
    else if (m_en && (m_rd == addr))  return m_data;
    else if (w_en && (w_rd == addr))  return w_data;
    else                              return rf_data;
  endfunction

  logic [DATA_WIDTH-1:0] w_rs1v, w_rs2v, w_op2, w_bus_a, w_bus_b;
  logic [3:0]            w_ctrl;
  logic                  w_is_shift;

  assign w_rs1v = resolve_src(in_rs1_addr, in_rs1_data, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                              wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  assign w_rs2v = resolve_src(in_rs2_addr, in_rs2_data, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                              wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  assign w_op2  = in_is_imm ? in_imm : w_rs2v;

  // Immediate forms only carry the arith bit for SRAI, so ADDI never turns into SUB.
  assign w_ctrl = {in_funct3, in_is_imm ? ((in_funct3 == F3_SR) & in_funct7b5) : in_funct7b5};
  assign w_is_shift = (in_funct3 == F3_SLL) || (in_funct3 == F3_SR);

  // ALU computes bus_B - bus_A and shifts bus_B by bus_A.
  always_comb begin
    w_bus_a = w_rs1v;
    w_bus_b = w_op2;
    if (w_is_shift) begin
      w_bus_a = {{(DATA_WIDTH-5){1'b0}}, w_op2[4:0]};
      w_bus_b = w_rs1v;
    end else if (w_ctrl == CTRL_SUB) begin
      w_bus_a = w_rs2v;
      w_bus_b = w_rs1v;
    end
  end

  logic                  r_main_valid, r_skid_valid, r_in_ready;
  logic [DATA_WIDTH-1:0] r_main_a, r_main_b, r_skid_a, r_skid_b;
  logic [3:0]            r_main_ctrl, r_skid_ctrl;
  logic [4:0]            r_main_rd, r_skid_rd;
  logic [31:0]           r_issue_count;

  logic w_accept, w_deliver, w_main_free;
  logic w_load_main_skid, w_load_main_in, w_load_skid;
  logic w_main_valid_nxt, w_skid_valid_nxt;

  assign w_accept    = in_valid & r_in_ready;
  assign w_deliver   = r_main_valid & out_ready;
  assign w_main_free = ~r_main_valid | out_ready;

  assign w_load_main_skid = w_main_free & r_skid_valid;
  assign w_load_main_in   = w_main_free & ~r_skid_valid & w_accept;
  assign w_load_skid      = w_accept & (r_skid_valid | ~w_main_free);

  assign w_main_valid_nxt = flush ? 1'b0 : (w_main_free ? (r_skid_valid | w_accept) : 1'b1);
  assign w_skid_valid_nxt = flush ? 1'b0 :
                            (w_main_free ? (r_skid_valid & w_accept) : (r_skid_valid | w_accept));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid  <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_in_ready    <= 1'b1;
      r_issue_count <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      if (w_deliver) r_issue_count <= r_issue_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_a    <= '0;
      r_main_b    <= '0;
      r_main_ctrl <= '0;
      r_main_rd   <= '0;
    end else if (w_load_main_skid) begin
      r_main_a    <= r_skid_a;
      r_main_b    <= r_skid_b;
      r_main_ctrl <= r_skid_ctrl;
      r_main_rd   <= r_skid_rd;
    end else if (w_load_main_in) begin
      r_main_a    <= w_bus_a;
      r_main_b    <= w_bus_b;
      r_main_ctrl <= w_ctrl;
      r_main_rd   <= in_rd_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_a    <= '0;
      r_skid_b    <= '0;
      r_skid_ctrl <= '0;
      r_skid_rd   <= '0;
    end else if (w_load_skid) begin
      r_skid_a    <= w_bus_a;
      r_skid_b    <= w_bus_b;
      r_skid_ctrl <= w_ctrl;
      r_skid_rd   <= in_rd_addr;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_valid;
  assign bus_A       = r_main_a;
  assign bus_B       = r_main_b;
  assign alu_ctrl    = r_main_ctrl;
  assign out_rd_addr = r_main_rd;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, backpressure/flush/reset
// sequences, and randomized traffic against an occupancy-queue reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush, in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7b5, in_is_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] bus_A, bus_B;
  logic [3:0]  alu_ctrl;
  logic [4:0]  out_rd_addr;
  logic [31:0] issue_count;

  alu_operand_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_is_imm(in_is_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .bus_A(bus_A), .bus_B(bus_B),
    .alu_ctrl(alu_ctrl), .out_rd_addr(out_rd_addr), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic        b5;
    logic        imm_f;
    logic [4:0]  rs1a, rs2a, rd;
    logic [31:0] rs1d, rs2d, imm;
    logic        men;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [31:0] ea, eb;
    logic [3:0]  ec;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        q[$];
  logic        exp_ready;
  logic [31:0] exp_count;
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_src(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'd0;
    if (mem_fwd_en && mem_fwd_rd == a) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_rd == a) return wb_fwd_data;
    return rf;
  endfunction

  // Reference view of one op: what the ALU should see given the current inputs.
  function automatic exp_t m_op();
    exp_t e;
    logic [31:0] s1, s2, op2;
    int unsigned f3;
    s1  = m_src(in_rs1_addr, in_rs1_data);
    s2  = m_src(in_rs2_addr, in_rs2_data);
    op2 = in_is_imm ? in_imm : s2;
    f3  = in_funct3;
    e.ctrl = {in_funct3, (in_is_imm && f3 != 5) ? 1'b0 : in_funct7b5};
    e.rd   = in_rd_addr;
    if (f3 == 1 || f3 == 5) begin
      e.a = op2 % 32;
      e.b = s1;
    end else if (f3 == 0 && !in_is_imm && in_funct7b5) begin
      e.a = s2;
      e.b = s1;
    end else begin
      e.a = s1;
      e.b = op2;
    end
    return e;
  endfunction

  task automatic check_state();
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, exp_ready);
    chk("issue_count", issue_count, exp_count);
    if (q.size() != 0) begin
      chk("bus_A", bus_A, q[0].a);
      chk("bus_B", bus_B, q[0].b);
      chk("alu_ctrl", alu_ctrl, q[0].ctrl);
      chk("out_rd_addr", out_rd_addr, q[0].rd);
    end
  endtask

  // Called with inputs already driven; advances one clock and checks the result.
  task automatic tick();
    bit   acc, del;
    exp_t e;
    acc = in_valid && exp_ready;
    del = (q.size() != 0) && out_ready;
    e   = m_op();
    if (del) begin
      void'(q.pop_front());
      exp_count = exp_count + 1;
    end
    if (flush) q.delete();
    else if (acc) q.push_back(e);
    exp_ready = (q.size() < 2);
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; in_funct3 = 0; in_funct7b5 = 0; in_is_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic b5, input logic immf,
                          input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] rd);
    in_valid = 1; in_funct3 = f3; in_funct7b5 = b5; in_is_imm = immf;
    in_rs1_addr = r1; in_rs1_data = d1; in_rs2_addr = r2; in_rs2_data = d2;
    in_imm = imm; in_rd_addr = rd;
    mem_fwd_en = 0; wb_fwd_en = 0;
  endtask

  task automatic model_reset();
    q.delete();
    exp_ready = 1;
    exp_count = 0;
  endtask

  logic [31:0] base;

  initial begin
    idle_inputs();
    out_ready = 1;
    model_reset();

    //            f3    b5 imm rs1a rs2a rd  rs1d          rs2d          imm           men mrd md     wen wrd wd     ea            eb            ec
    vecs[0] = '{3'b000, 0, 0, 5'd1, 5'd2, 5'd4, 32'd5,        32'd7,        32'd0,        0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  32'd5,        32'd7,        4'b0000};
    vecs[1] = '{3'b000, 1, 0, 5'd1, 5'd2, 5'd5, 32'd10,       32'd3,        32'd0,        0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  32'd3,        32'd10,       4'b0001};
    vecs[2] = '{3'b000, 1, 1, 5'd1, 5'd2, 5'd6, 32'd100,      32'd9,        32'h40000005, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  32'd100,      32'h40000005, 4'b0000};
    vecs[3] = '{3'b101, 1, 1, 5'd1, 5'd2, 5'd7, 32'h80000000, 32'd9,        32'h00000404, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  32'd4,        32'h80000000, 4'b1011};
    vecs[4] = '{3'b000, 0, 0, 5'd3, 5'd5, 5'd8, 32'h99,       32'd1,        32'd0,        1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 32'h11,       32'd1,        4'b0000};
    vecs[5] = '{3'b000, 0, 0, 5'd0, 5'd5, 5'd9, 32'h55,       32'd1,        32'd0,        1, 5'd0, 32'h11, 1, 5'd0, 32'h22, 32'd0,        32'd1,        4'b0000};
    vecs[6] = '{3'b100, 0, 0, 5'd1, 5'd6, 5'd10, 32'hF0,      32'd77,       32'd0,        1, 5'd7, 32'h11, 1, 5'd6, 32'h22, 32'hF0,       32'h22,       4'b1000};
    vecs[7] = '{3'b001, 0, 0, 5'd1, 5'd2, 5'd11, 32'd1,       32'h23,       32'd0,        0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  32'd3,        32'd1,        4'b0010};
    vecs[8] = '{3'b101, 0, 1, 5'd1, 5'd2, 5'd12, 32'hF000000F, 32'd0,       32'h0000001F, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  32'd31,       32'hF000000F, 4'b1010};
    vecs[9] = '{3'b000, 1, 0, 5'd1, 5'd2, 5'd13, 32'd10,      32'd99,       32'd0,        1, 5'd2, 32'd4,  1, 5'd2, 32'd8,  32'd4,        32'd10,       4'b0001};

    repeat (2) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst bus_A", bus_A, 0);
    chk("rst bus_B", bus_B, 0);
    chk("rst alu_ctrl", alu_ctrl, 0);
    chk("rst rd", out_rd_addr, 0);
    chk("rst issue_count", issue_count, 0);
    rst = 0;
    tick();

    // Directed vectors, one op at a time through an empty stage.
    foreach (vecs[i]) begin
      drive_op(vecs[i].f3, vecs[i].b5, vecs[i].imm_f, vecs[i].rs1a, vecs[i].rs1d,
               vecs[i].rs2a, vecs[i].rs2d, vecs[i].imm, vecs[i].rd);
      mem_fwd_en = vecs[i].men; mem_fwd_rd = vecs[i].mrd; mem_fwd_data = vecs[i].md;
      wb_fwd_en  = vecs[i].wen; wb_fwd_rd  = vecs[i].wrd; wb_fwd_data  = vecs[i].wd;
      out_ready = 1;
      tick();
      chk($sformatf("vec%0d out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d bus_A", i), bus_A, vecs[i].ea);
      chk($sformatf("vec%0d bus_B", i), bus_B, vecs[i].eb);
      chk($sformatf("vec%0d alu_ctrl", i), alu_ctrl, vecs[i].ec);
      chk($sformatf("vec%0d rd", i), out_rd_addr, vecs[i].rd);
      idle_inputs();
      tick();
    end

    // Backpressure: A into main, B into skid, C held by decode.
    base = issue_count;
    out_ready = 0;
    drive_op(3'b000, 0, 0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd1);   tick();
    chk("bp in_ready after A", in_ready, 1);
    drive_op(3'b000, 1, 0, 5'd1, 32'd9, 5'd2, 32'd4, 32'd0, 5'd2);   tick();
    chk("bp in_ready after B", in_ready, 0);
    drive_op(3'b100, 0, 0, 5'd1, 32'd3, 5'd2, 32'd5, 32'd0, 5'd3);   tick();
    tick();
    chk("bp hold bus_A", bus_A, 1);
    chk("bp hold bus_B", bus_B, 2);
    out_ready = 1;
    tick();
    chk("bp B bus_A", bus_A, 4);
    chk("bp B bus_B", bus_B, 9);
    tick();
    chk("bp C bus_A", bus_A, 3);
    idle_inputs();
    tick();
    chk("bp delivered", issue_count - base, 3);

    // Flush with main full and an op accepted into the skid in the same cycle.
    out_ready = 0;
    drive_op(3'b000, 0, 0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd1);   tick();
    drive_op(3'b110, 0, 0, 5'd1, 32'd6, 5'd2, 32'd7, 32'd0, 5'd2);
    flush = 1;
    tick();
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    idle_inputs();
    out_ready = 1;
    base = issue_count;
    tick();
    chk("flush nothing delivered", issue_count - base, 0);

    // Flush with both entries full, handshake in the flush cycle still counts.
    out_ready = 0;
    drive_op(3'b000, 0, 0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd1);   tick();
    drive_op(3'b000, 0, 0, 5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 5'd2);   tick();
    base = issue_count;
    flush = 1; out_ready = 1;
    tick();
    chk("flush2 count", issue_count - base, 1);
    chk("flush2 out_valid", out_valid, 0);
    chk("flush2 in_ready", in_ready, 1);
    idle_inputs();
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      in_valid     = ($urandom % 4) != 0;
      out_ready    = ($urandom % 3) != 0;
      flush        = ($urandom % 40) == 0;
      in_funct3    = 3'($urandom);
      in_funct7b5  = 1'($urandom);
      in_is_imm    = 1'($urandom);
      in_rs1_addr  = 5'($urandom % 8);
      in_rs2_addr  = 5'($urandom % 8);
      in_rd_addr   = 5'($urandom);
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_imm       = $urandom;
      mem_fwd_en   = 1'($urandom);
      mem_fwd_rd   = 5'($urandom % 8);
      mem_fwd_data = $urandom;
      wb_fwd_en    = 1'($urandom);
      wb_fwd_rd    = 5'($urandom % 8);
      wb_fwd_data  = $urandom;
      tick();
    end
    idle_inputs();
    out_ready = 1;
    repeat (3) tick();

    // Asynchronous reset mid-stream with both entries occupied.
    out_ready = 0;
    drive_op(3'b000, 0, 0, 5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 5'd7);   tick();
    drive_op(3'b000, 1, 0, 5'd1, 32'd8, 5'd2, 32'd2, 32'd0, 5'd9);   tick();
    rst = 1;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst in_ready", in_ready, 1);
    chk("arst bus_A", bus_A, 0);
    chk("arst bus_B", bus_B, 0);
    chk("arst alu_ctrl", alu_ctrl, 0);
    chk("arst rd", out_rd_addr, 0);
    chk("arst issue_count", issue_count, 0);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    out_ready = 1;
    drive_op(3'b000, 0, 0, 5'd1, 32'd20, 5'd2, 32'd22, 32'd0, 5'd3); tick();
    chk("post-rst bus_B", bus_B, 22);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
